// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   - Access size encodings carried on req_size_i
//   - FSM state enumeration used by lsu_mem_ctrl
//   - isMisaligned(): decides if a request must be rejected instead of
//     touching memory (halves need an even address, words a 4-byte aligned
//     address, size 2'b11 is never legal)
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } lsu_state_e;

   function automatic logic isMisaligned(input logic [1:0] size,
                                         input logic [1:0] addrLo);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addrLo[0];
         SZ_WORD: bad = (addrLo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_unit.sv
// Combinational byte-lane unit, shared by the load path and the sub-word
// store read-modify-write path. Lanes are little-endian within the word.
// Ports:
//   size_i        access size (byte/half/word)
//   addr_lo_i     byte offset inside the word (addr[1:0])
//   unsigned_i    zero-extend loads when 1, sign-extend when 0
//   mem_word_i    word read from memory
//   store_data_i  right-aligned store data
//   load_data_o   selected lane, extended to 32 bits
//   merge_word_o  mem_word_i with the addressed lane replaced by store data
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] mem_word_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_word_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        signBit;

   // Pick the addressed byte and halfword out of the memory word.
   always_comb begin
      byteSel = mem_word_i[7:0];
      case (addr_lo_i)
         2'd0:    byteSel = mem_word_i[7:0];
         2'd1:    byteSel = mem_word_i[15:8];
         2'd2:    byteSel = mem_word_i[23:16];
         default: byteSel = mem_word_i[31:24];
      endcase
      halfSel = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
   end

   // Extend the selected lane; the fill bit is the lane's MSB for signed
   // loads and zero for unsigned ones.
   always_comb begin
      load_data_o = mem_word_i;
      signBit     = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            signBit     = byteSel[7] & ~unsigned_i;
            load_data_o = {{24{signBit}}, byteSel};
         end
         SZ_HALF: begin
            signBit     = halfSel[15] & ~unsigned_i;
            load_data_o = {{16{signBit}}, halfSel};
         end
         default: load_data_o = mem_word_i;
      endcase
   end

   // Build the write-back word for sub-word stores: keep every lane of the
   // old word except the one being stored.
   always_comb begin
      merge_word_o = mem_word_i;
      case (size_i)
         SZ_BYTE: begin
            case (addr_lo_i)
               2'd0:    merge_word_o[7:0]   = store_data_i[7:0];
               2'd1:    merge_word_o[15:8]  = store_data_i[7:0];
               2'd2:    merge_word_o[23:16] = store_data_i[7:0];
               default: merge_word_o[31:24] = store_data_i[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo_i[1]) merge_word_o[31:16] = store_data_i[15:0];
            else              merge_word_o[15:0]  = store_data_i[15:0];
         end
         default: merge_word_o = store_data_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving a 32-bit word-wide data memory that has no
// byte enables. One request is in flight at a time.
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o   request handshake; accepted when both are 1
//   req_we_i              1 = store, 0 = load
//   req_size_i            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i        zero-extend loads when 1
//   req_addr_i            byte address
//   req_wdata_i           right-aligned store data
//   rsp_valid_o           one-cycle completion pulse
//   rsp_rdata_o           extended load data, 0 for stores and rejects
//   rsp_misalign_o        request was rejected as misaligned
//   mem_address_o         word address to memory
//   mem_wdata_o           write word (0 outside a write cycle)
//   mem_memwrite_o        write strobe, memory commits on the rising edge
//   mem_memread_o         read enable
//   mem_rdata_i           combinational read data from memory
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 6
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W+1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_misalign_o,
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [31:0]       mem_wdata_o,
   output logic              mem_memwrite_o,
   output logic              mem_memread_o,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_e        state_q, state_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       merge_q;
   logic              misalign_q;

   logic              accept;
   logic              reqMisaligned;
   logic [31:0]       laneLoad;
   logic [31:0]       laneMerge;

   assign accept        = req_valid_i && (state_q == IDLE);
   assign reqMisaligned = isMisaligned(req_size_i, req_addr_i[1:0]);

   // One lane unit serves both loads and the read half of a
   // read-modify-write, always working on the latched request.
   lsu_lane_unit u_lane (
      .size_i       (size_q),
      .addr_lo_i    (addr_q[1:0]),
      .unsigned_i   (unsigned_q),
      .mem_word_i   (mem_rdata_i),
      .store_data_i (wdata_q),
      .load_data_o  (laneLoad),
      .merge_word_o (laneMerge)
   );

   // State register; reset drops any in-flight request without a response.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic. Rejected requests go straight to RESP, word stores
   // skip the read, sub-word stores read the old word first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (reqMisaligned)            state_d = RESP;
               else if (!req_we_i)           state_d = LOAD;
               else if (req_size_i == SZ_WORD) state_d = WRITE;
               else                          state_d = RMW_RD;
            end
         end
         LOAD:    state_d = RESP;
         RMW_RD:  state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch plus the two data registers fed by the lane unit.
   // rdata_q is cleared at acceptance so stores and rejects report zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         merge_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (accept) begin
            we_q       <= req_we_i;
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            misalign_q <= reqMisaligned;
            rdata_q    <= '0;
         end
         if (state_q == LOAD)   rdata_q <= laneLoad;
         if (state_q == RMW_RD) merge_q <= laneMerge;
      end
   end

   // Output decode. The write strobe is gated by reset so a reset landing
   // on a WRITE cycle can never corrupt memory.
   always_comb begin
      req_ready_o    = (state_q == IDLE);
      rsp_valid_o    = (state_q == RESP);
      rsp_misalign_o = (state_q == RESP) && misalign_q;
      rsp_rdata_o    = rdata_q;
      mem_address_o  = addr_q[ADDR_W+1:2];
      mem_memread_o  = (state_q == LOAD) || (state_q == RMW_RD);
      mem_memwrite_o = (state_q == WRITE) && !rst_i;
      mem_wdata_o    = '0;
      if (state_q == WRITE) begin
         mem_wdata_o = (we_q && size_q == SZ_WORD) ? wdata_q : merge_q;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl. A behavioural memory model predicts
// every response, strobe and write word; a negedge compare process checks
// the DUT each cycle, and directed requests pin known literal results.
module tb_lsu_mem_ctrl;

   localparam int ADDR_W = 6;
   localparam int NWORDS = 1 << ADDR_W;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_we_i = 1'b0;
   logic [1:0]        req_size_i = 2'b00;
   logic              req_unsigned_i = 1'b0;
   logic [ADDR_W+1:0] req_addr_i = '0;
   logic [31:0]       req_wdata_i = '0;
   logic              rsp_valid_o;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_misalign_o;
   logic [ADDR_W-1:0] mem_address_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_memwrite_o;
   logic              mem_memread_o;
   logic [31:0]       mem_rdata_i;

   int checks = 0;
   int errors = 0;
   int edgeCount = 0;

   logic [31:0] seedMem  [NWORDS];
   logic [31:0] envMem   [NWORDS];
   logic [31:0] modelMem [NWORDS];
   logic        loadMem = 1'b1;

   // Pending request as predicted by the model.
   logic        pendValid = 1'b0;
   int          pendAccept, pendLat, pendWrOff;
   logic        pendRd;
   logic [31:0] pendRdata, pendWrWord;
   logic        pendMis;
   logic [ADDR_W-1:0] pendWord;

   lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_misalign_o (rsp_misalign_o),
      .mem_address_o  (mem_address_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_memwrite_o (mem_memwrite_o),
      .mem_memread_o  (mem_memread_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) edgeCount <= edgeCount + 1;

   // Data memory seen by the DUT: combinational read, write on rising edge.
   assign mem_rdata_i = envMem[mem_address_o];
   always @(posedge clk_i) begin
      if (loadMem) begin
         for (int i = 0; i < NWORDS; i++) envMem[i] <= seedMem[i];
      end else if (mem_memwrite_o) begin
         envMem[mem_address_o] <= mem_wdata_o;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Model of one accepted request, straight from the access rules.
   task automatic modelAccept(input int cyc);
      logic [31:0] w, lane, mask, data;
      int          k, sh;
      k  = int'(req_addr_i[1:0]);
      w  = modelMem[req_addr_i[ADDR_W+1:2]];
      pendValid  = 1'b1;
      pendAccept = cyc;
      pendWord   = req_addr_i[ADDR_W+1:2];
      pendRd     = 1'b0;
      pendWrOff  = 0;
      pendRdata  = 32'd0;
      pendWrWord = 32'd0;
      pendMis    = (req_size_i == 2'd3) || (req_size_i == 2'd1 && k % 2 == 1)
                   || (req_size_i == 2'd2 && k != 0);
      if (pendMis) begin
         pendLat = 1;
      end else if (!req_we_i) begin
         pendLat = 2;
         pendRd  = 1'b1;
         if (req_size_i == 2'd0) begin
            lane = (w >> (8 * k)) & 32'hFF;
            if (!req_unsigned_i && lane >= 32'h80) lane = lane + 32'hFFFFFF00;
         end else if (req_size_i == 2'd1) begin
            lane = (w >> (16 * (k / 2))) & 32'hFFFF;
            if (!req_unsigned_i && lane >= 32'h8000) lane = lane + 32'hFFFF0000;
         end else begin
            lane = w;
         end
         pendRdata = lane;
      end else if (req_size_i == 2'd2) begin
         pendLat    = 2;
         pendWrOff  = 1;
         pendWrWord = req_wdata_i;
      end else begin
         pendLat   = 3;
         pendRd    = 1'b1;
         pendWrOff = 2;
         sh   = (req_size_i == 2'd0) ? 8 * k : 16 * (k / 2);
         mask = ((req_size_i == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
         data = (req_wdata_i << sh) & mask;
         pendWrWord = (w & ~mask) | data;
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk_i) begin
      logic expReady, expRd, expWr, expRsp;
      int   cyc;
      if (rst_i) begin
         if (loadMem) begin
            for (int i = 0; i < NWORDS; i++) modelMem[i] = seedMem[i];
         end
         checkOutput("memwrite_during_reset", {31'd0, mem_memwrite_o}, 32'd0);
         pendValid = 1'b0;
      end else begin
         cyc      = edgeCount;
         expReady = !pendValid;
         expRd    = pendValid && pendRd && (cyc == pendAccept + 1);
         expWr    = pendValid && (pendWrOff != 0) && (cyc == pendAccept + pendWrOff);
         expRsp   = pendValid && (cyc == pendAccept + pendLat);
         checkOutput("req_ready", {31'd0, req_ready_o}, {31'd0, expReady});
         checkOutput("memread", {31'd0, mem_memread_o}, {31'd0, expRd});
         checkOutput("memwrite", {31'd0, mem_memwrite_o}, {31'd0, expWr});
         checkOutput("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, expRsp});
         if (expRd || expWr) begin
            checkOutput("mem_address", {26'd0, mem_address_o}, {26'd0, pendWord});
         end
         if (expWr) begin
            checkOutput("mem_wdata", mem_wdata_o, pendWrWord);
            modelMem[pendWord] = pendWrWord;
         end else begin
            checkOutput("mem_wdata_idle", mem_wdata_o, 32'd0);
         end
         if (expRsp) begin
            checkOutput("rsp_rdata", rsp_rdata_o, pendRdata);
            checkOutput("rsp_misalign", {31'd0, rsp_misalign_o}, {31'd0, pendMis});
            pendValid = 1'b0;
         end
         if (expReady && req_valid_i) modelAccept(cyc);
      end
   end

   // Issue one request, wait for acceptance and for its response.
   task automatic applyStimulus(input logic we, input logic [1:0] size,
                                input logic uns, input logic [7:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic mis,
                                output int lat);
      logic accepted, rdyNow, got;
      int   acceptEdge;
      rdata = 32'd0;
      mis   = 1'b0;
      lat   = -1;
      @(posedge clk_i); #1;
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk_i);
         rdyNow = req_ready_o && !rst_i;
         @(posedge clk_i); #1;
         if (rdyNow) accepted = 1'b1;
      end
      acceptEdge  = edgeCount;
      req_valid_i = 1'b0;
      if (!accepted) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
      end else begin
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
               got   = 1'b1;
               rdata = rsp_rdata_o;
               mis   = rsp_misalign_o;
               lat   = edgeCount + 1 - acceptEdge;
            end
         end
         if (!got) checkOutput("response_timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin
      logic [31:0] r;
      logic        m;
      int          l, firstAcc, secondAcc, nAcc;
      logic [31:0] saved;

      for (int i = 0; i < NWORDS; i++) seedMem[i] = $urandom;
      seedMem[2] = 32'h8899AABB;

      repeat (3) @(posedge clk_i);
      #1;
      rst_i   = 1'b0;
      loadMem = 1'b0;
      @(negedge clk_i);
      checkOutput("reset_ready", {31'd0, req_ready_o}, 32'd1);
      checkOutput("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("reset_misalign", {31'd0, rsp_misalign_o}, 32'd0);
      checkOutput("reset_rdata", rsp_rdata_o, 32'd0);
      checkOutput("reset_memread", {31'd0, mem_memread_o}, 32'd0);
      checkOutput("reset_address", {26'd0, mem_address_o}, 32'd0);

      applyStimulus(1'b0, 2'd2, 1'b0, 8'h08, 32'd0, r, m, l);
      checkOutput("lw_data", r, 32'h8899AABB);
      checkOutput("lw_latency", 32'(l), 32'd2);
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h0B, 32'd0, r, m, l);
      checkOutput("lb_data", r, 32'hFFFFFF88);
      applyStimulus(1'b0, 2'd0, 1'b1, 8'h0B, 32'd0, r, m, l);
      checkOutput("lbu_data", r, 32'h00000088);
      applyStimulus(1'b0, 2'd1, 1'b0, 8'h0A, 32'd0, r, m, l);
      checkOutput("lh_data", r, 32'hFFFF8899);
      applyStimulus(1'b0, 2'd1, 1'b1, 8'h08, 32'd0, r, m, l);
      checkOutput("lhu_data", r, 32'h0000AABB);

      applyStimulus(1'b1, 2'd0, 1'b0, 8'h09, 32'h12345677, r, m, l);
      checkOutput("sb_latency", 32'(l), 32'd3);
      checkOutput("sb_rdata", r, 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h08, 32'd0, r, m, l);
      checkOutput("sb_readback", r, 32'h889977BB);

      applyStimulus(1'b1, 2'd2, 1'b0, 8'h08, 32'h8899AABB, r, m, l);
      applyStimulus(1'b1, 2'd1, 1'b0, 8'h0A, 32'h0000CAFE, r, m, l);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h08, 32'd0, r, m, l);
      checkOutput("sh_readback", r, 32'hCAFEAABB);

      applyStimulus(1'b1, 2'd2, 1'b0, 8'h0C, 32'hDEADBEEF, r, m, l);
      checkOutput("sw_latency", 32'(l), 32'd2);
      applyStimulus(1'b0, 2'd2, 1'b0, 8'h0C, 32'd0, r, m, l);
      checkOutput("sw_readback", r, 32'hDEADBEEF);

      applyStimulus(1'b0, 2'd2, 1'b0, 8'h06, 32'd0, r, m, l);
      checkOutput("lw_mis_flag", {31'd0, m}, 32'd1);
      checkOutput("lw_mis_latency", 32'(l), 32'd1);
      checkOutput("lw_mis_rdata", r, 32'd0);
      applyStimulus(1'b1, 2'd1, 1'b0, 8'h05, 32'hFFFF, r, m, l);
      checkOutput("sh_mis_flag", {31'd0, m}, 32'd1);
      applyStimulus(1'b0, 2'd3, 1'b0, 8'h00, 32'd0, r, m, l);
      checkOutput("size3_mis_flag", {31'd0, m}, 32'd1);
      checkOutput("size3_mis_latency", 32'(l), 32'd1);

      // Reset during the WRITE cycle of a byte store.
      saved = envMem[4];
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0;
      req_addr_i  = 8'h11; req_wdata_i = 32'h000000A5;
      @(negedge clk_i);
      checkOutput("rst_test_ready", {31'd0, req_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_write_blocked", {31'd0, mem_memwrite_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("ready_after_reset", {31'd0, req_ready_o}, 32'd1);
      checkOutput("no_rsp_after_reset", {31'd0, rsp_valid_o}, 32'd0);
      checkOutput("mem_unchanged_after_reset", envMem[4], saved);

      // Hold valid across a load; the second acceptance follows RESP.
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
      req_addr_i  = 8'h0C; req_unsigned_i = 1'b0;
      nAcc = 0; firstAcc = 0; secondAcc = 0;
      for (int i = 0; i < 20 && nAcc < 2; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            nAcc++;
            if (nAcc == 1) firstAcc = edgeCount;
            else           secondAcc = edgeCount;
         end
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      checkOutput("hold_accepts", 32'(nAcc), 32'd2);
      checkOutput("hold_spacing", 32'(secondAcc - firstAcc), 32'd3);
      repeat (4) @(posedge clk_i);

      // Randomized traffic over the first eight words.
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                       $urandom, r, m, l);
      end
      repeat (3) @(posedge clk_i);

      for (int i = 0; i < NWORDS; i++) begin
         checkOutput("final_memory", envMem[i], modelMem[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
